// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - register bus, peripheral requests and Z80 acknowledge signals
interface int_controller_if #(
    parameter int NUM_SRC = 8
);
    logic               wr_n;
    logic [7:0]         reg_addr_i;
    logic [7:0]         data_i;
    logic               int_cs;
    logic [7:0]         data_o;
    logic [NUM_SRC-1:0] irq_i;
    logic               m1_n;
    logic               ioreq_n;
    logic               int_n_o;
    logic               ack_o;
    logic [7:0]         vec_o;

    modport master (
        output wr_n, reg_addr_i, data_i, int_cs, irq_i, m1_n, ioreq_n,
        input  data_o, int_n_o, ack_o, vec_o
    );

    modport slave (
        input  wr_n, reg_addr_i, data_i, int_cs, irq_i, m1_n, ioreq_n,
        output data_o, int_n_o, ack_o, vec_o
    );
endinterface

// File: rtl/int_controller.sv
// rtl/int_controller.sv - Z80 IM2 interrupt controller with edge-detected sources and EOI
module int_controller #(
    parameter int NUM_SRC = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    int_controller_if.slave      bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [3:0]         vecbase_q, vecbase_d;
    logic               in_service_q, in_service_d;
    logic [2:0]         isr_idx_q, isr_idx_d;
    logic [2:0]         idx_q, idx_d;
    logic               int_n_q, int_n_d;
    logic               ack_q, ack_d;
    logic [7:0]         vec_q, vec_d;

    logic               wr_en;
    logic               iack;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic [2:0]         win_idx;
    logic [7:0]         pend_rd, en_rd;

    assign wr_en    = bus.int_cs & ~bus.wr_n;
    assign iack     = ~bus.m1_n & ~bus.ioreq_n;
    assign active   = pending_q & enable_q;
    assign pend_set = bus.irq_i & ~irq_q;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = bus.irq_i;
        enable_d     = enable_q;
        vecbase_d    = vecbase_q;
        in_service_d = in_service_q;
        isr_idx_d    = isr_idx_q;
        idx_d        = idx_q;
        ack_d        = ack_q;
        vec_d        = vec_q;
        pend_clr     = '0;

        if (wr_en) begin
            case (bus.reg_addr_i)
                8'h00:   pend_clr  = bus.data_i[NUM_SRC-1:0];
                8'h01:   enable_d  = bus.data_i[NUM_SRC-1:0];
                8'h02:   vecbase_d = bus.data_i[7:4];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (active != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (active == '0) begin
                    state_d = ST_IDLE;
                end else if (iack) begin
                    idx_d   = win_idx;
                    vec_d   = {vecbase_q, win_idx, 1'b0};
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!iack) begin
                    ack_d        = 1'b0;
                    pend_clr[idx_q] = 1'b1;
                    in_service_d = 1'b1;
                    isr_idx_d    = idx_q;
                    state_d      = ST_SERVICE;
                end
            end
            default: begin
                if (wr_en && bus.reg_addr_i == 8'h03) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
        endcase

        // A fresh edge outranks any clear landing on the same bit.
        pending_d = (pending_q & ~pend_clr) | pend_set;
        int_n_d   = (state_d != ST_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            vecbase_q    <= '0;
            in_service_q <= 1'b0;
            isr_idx_q    <= '0;
            idx_q        <= '0;
            int_n_q      <= 1'b1;
            ack_q        <= 1'b0;
            vec_q        <= '0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            vecbase_q    <= vecbase_d;
            in_service_q <= in_service_d;
            isr_idx_q    <= isr_idx_d;
            idx_q        <= idx_d;
            int_n_q      <= int_n_d;
            ack_q        <= ack_d;
            vec_q        <= vec_d;
        end
    end

    always_comb begin
        pend_rd = '0;
        en_rd   = '0;
        pend_rd[NUM_SRC-1:0] = pending_q;
        en_rd[NUM_SRC-1:0]   = enable_q;
        case (bus.reg_addr_i)
            8'h00:   bus.data_o = pend_rd;
            8'h01:   bus.data_o = en_rd;
            8'h02:   bus.data_o = {vecbase_q, 4'b0};
            8'h03:   bus.data_o = {in_service_q, 4'b0, isr_idx_q};
            default: bus.data_o = 8'h00;
        endcase
    end

    assign bus.int_n_o = int_n_q;
    assign bus.ack_o   = ack_q;
    assign bus.vec_o   = vec_q;
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Z80 mode-2 (IM2) interrupt controller. It sits directly upstream of the CPU's int_n input, which is currently tied high, and gathers interrupt requests from the peripherals (uart, usb, sd, video, gpio).
- It drives int_n low, answers the CPU interrupt-acknowledge cycle (M1 and IORQ low together) with an 8-bit vector, and tracks in-service state until software issues end-of-interrupt.
- Software accesses it as an I/O peripheral selected by addr_decoder via int_cs.

Parameters:
- NUM_SRC, 8: number of interrupt sources (1..8). Index 0 has the highest priority.

Ports:
- clk_i  input  1  system clock, same as the CPU clock
- rst_n_i  input  1  reset, synchronous, active-low
- wr_n  input  1  CPU write strobe, active-low
- reg_addr_i  input  8  register address, driven from cpu_addr[7:0]
- data_i  input  8  CPU write data
- int_cs  input  1  chip select from addr_decoder (I/O space)
- data_o  output  8  register read data, combinational from reg_addr_i
- irq_i  input  NUM_SRC  peripheral interrupt requests, active-high, rising-edge sensitive
- m1_n  input  1  CPU M1, active-low
- ioreq_n  input  1  CPU IORQ, active-low
- int_n_o  output  1  interrupt request to the CPU, active-low
- ack_o  output  1  high while the vector is being supplied; top-level data mux selects vec_o with highest priority
- vec_o  output  8  IM2 vector

Behaviour:
- Register map (reg_addr_i[7:0]); a write occurs on every clk_i edge where int_cs=1 and wr_n=0:
  - 0x00 PENDING: read. Write 1 to a bit to clear it.
  - 0x01 ENABLE: read/write mask. Bits at or above NUM_SRC read 0.
  - 0x02 VECBASE: read/write, bits [7:4] stored, bits [3:0] read 0.
  - 0x03 STATUS: read gives {in_service, 4'b0, isr_idx[2:0]}. Any write is an EOI.
  - Other addresses read 0x00 and ignore writes.
- Edge detect: irq_i is registered once into irq_q. pend_set = irq_i & ~irq_q sets PENDING on the next edge.
  - If set and W1C hit the same bit in the same cycle, set wins.
  - A request that is held high raises only one pending event.
- Vector: vec_o = {VECBASE[7:4], idx[2:0], 1'b0}. This is always even.
  - idx is the lowest set bit of (PENDING & ENABLE), latched at acknowledge.
- FSM states: IDLE, REQ, ACK, SERVICE.
  - IDLE: if (PENDING & ENABLE) != 0, go to REQ and drive int_n_o=0 from the next cycle.
  - REQ: int_n_o=0.
    - If (PENDING & ENABLE) becomes 0 (software clear or disable), go to IDLE and set int_n_o=1 next cycle.
    - If m1_n=0 and ioreq_n=0, latch idx, drive vec_o, assert ack_o (registered, valid one cycle after acknowledge detect), and go to ACK.
  - ACK: ack_o=1 and vec_o held for as long as m1_n=0 and ioreq_n=0.
    - When either goes high: ack_o=0, int_n_o=1, clear PENDING[idx], set in_service=1, isr_idx=idx, go to SERVICE.
  - SERVICE: int_n_o=1; further pending events accumulate.
    - On EOI write: in_service=0, go to IDLE.
  - An EOI in any other state is ignored.
- Priority is fixed; lowest index wins. The winner is frozen at acknowledge entry and is not re-evaluated during ACK.
- No nesting: at most one source is in service.
- Reset (rst_n_i=0 at an edge), from any state including mid-ACK:
  - state=IDLE, int_n_o=1, ack_o=0, vec_o=0x00.
  - PENDING=0, ENABLE=0, VECBASE=0, in_service=0, isr_idx=0, irq_q=0.
  - data_o therefore reads 0x00 at all defined addresses.
  - Rising edges during reset are discarded.
- Every output changes only on clk_i edges except data_o, which is combinational.

Test Plan:
- Reset, then read 0x00..0x03: all read 0x00, int_n_o=1, ack_o=0. A pulse on irq_i[3] with ENABLE=0: PENDING=0x08, int_n_o stays 1.
- Write VECBASE=0xA0, ENABLE=0xFF, then pulse irq_i[5] and irq_i[2] in the same cycle: int_n_o=0 two cycles later. Drive m1_n=ioreq_n=0: ack_o=1, vec_o=0xA4. Release: PENDING=0x20, STATUS=0x82, int_n_o=1.
- From the previous state, write STATUS (EOI): the next cycle has int_n_o=0 and the following acknowledge returns vec_o=0xAA.
- In REQ, write 0x01 to PENDING to clear the only source: int_n_o returns to 1, state IDLE, no ack_o on a later acknowledge cycle.
- Hold irq_i[0] high for 100 cycles with a W1C of bit 0 at cycle 50: exactly one pending event, bit 0 is 0 after the clear. Coincident rising edge and W1C on the same bit: bit remains 1.
- Assert rst_n_i during ACK: the next cycle has ack_o=0, vec_o=0x00, int_n_o=1, all registers 0x00, and no stale interrupt after reset is released.
